aes_sbox_engine: RTL and testbench
==================================

Name: aes_sbox_engine

Overview:
Multi-cycle, parametrised AES byte-substitution engine. It substitutes an NBYTES-byte state through either the forward S-box or the inverse S-box, processing LANES bytes per clock. Valid/ready handshakes on both sides let the AES round controller trade area against throughput by choosing LANES. It sits between the round key/state registers and ShiftRows / InvShiftRows.

Parameters:
NBYTES, 16, bytes in the state word; state width is 8*NBYTES.
LANES, 4, S-box lookups per cycle; must divide NBYTES; legal values are 1, 2, 4, 8, 16.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input state and mode are valid
in_ready  out  1  engine can accept a state
in_state  in  8*NBYTES  state to substitute; byte k = in_state[8k+:8]
in_inv  in  1  0 = forward S-box (encrypt); 1 = inverse S-box (decrypt)
out_valid  out  1  out_state holds a finished result
out_ready  in  1  consumer accepts the result
out_state  out  8*NBYTES  substituted state, same byte ordering
out_inv  out  1  mode the result was produced with
busy  out  1  high while in BUSY

Behaviour:
- STEPS = NBYTES/LANES. Counter width is clog2(STEPS), minimum 1 bit.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch in_state into the working register and latch in_inv; clear cnt; go to BUSY.
  - BUSY: in_ready=0, busy=1. Each edge replaces bytes [cnt*LANES, cnt*LANES+LANES-1] of the working register with their lookup under the latched mode, then increments cnt. The edge that processes group STEPS-1 goes to DONE.
  - DONE: out_valid=1; out_state and out_inv are stable. On out_ready, go to IDLE.
- Latency:
  - out_valid rises STEPS edges after the accepting edge.
  - LANES=16, NBYTES=16 gives 1 cycle; LANES=1 gives 16 cycles.
- No accept in DONE. in_ready=0 until the result is taken. The earliest next accept is the edge after the one where out_ready is sampled high. Throughput is therefore one state per STEPS+2 cycles with out_ready held high.
- Bytes are processed in ascending order, lowest index first.
- Mode is captured only at accept. Changing in_inv or in_state while BUSY has no effect.
- out_state is driven directly from the working register. Partially substituted contents are visible while BUSY but are meaningful only while out_valid=1.
- Lookup tables are FIPS-197 forward S-box and inverse S-box. Lookups are combinational; no table pipeline stage.
- Reset (async assert, synchronous release): state=IDLE, cnt=0, working register=0, out_inv=0. Outputs: in_ready=1, out_valid=0, busy=0, out_state=0.
- Reset asserted mid-BUSY or mid-DONE discards the operation; no partial result is ever flagged valid.
- Illegal LANES (not dividing NBYTES) is an elaboration error via a generate-time check.

Decomposition:
- Shared package aes_pkg holds:
  - the 256-entry forward and inverse S-box constant arrays;
  - the AES_BYTE_W=8 constant;
  - the FSM state enum {IDLE, BUSY, DONE}.
- Sub-module aes_sbox_lane: combinational, 8-bit in, 8-bit out, inv select. It indexes the package tables and is instantiated LANES times.
- Lane inputs are muxed from the working register by cnt. Outputs are written back to the same slice.

Test Plan:
1. Forward, LANES=4: in_state all 0x00, in_inv=0 -> out_state all 0x63, out_inv=0; out_valid rises exactly 4 edges after accept; busy high for 4 cycles.
2. Inverse, LANES=4: in_state all 0x00 -> all 0x52. Single-byte checks: 0x63->0x00, 0x7d->0x13, 0xff->0x7d.
3. Round trip, LANES=1 and LANES=16: random 128-bit X forward, then result inverse -> X. Latencies are 16 and 1 respectively.
4. Backpressure: hold out_ready=0 for 10 cycles after out_valid.
   - Required: out_state/out_valid stable, in_ready=0, and in_valid pulses ignored.
   - On out_ready=1: in_ready=1 next cycle, and a new state is accepted.
5. Mode/data isolation: accept 0x00112233_44556677_8899aabb_ccddeeff with in_inv=0, then flip in_inv and in_state during BUSY -> result equals the forward S-box of the original, out_inv=0.
6. Reset mid-BUSY at cnt=2 (LANES=4) -> outputs return to reset values immediately; no out_valid pulse. The next accepted state completes normally with full latency.

Source files
------------

// File: rtl/aes_sbox_engine_pkg.sv
// Shared definitions for the AES byte-substitution engine.
//   AES_BYTE_W  : width of one state byte
//   aes_state_e : engine control states
//   SBOX_FWD    : FIPS-197 forward S-box (encrypt)
//   SBOX_INV    : FIPS-197 inverse S-box (decrypt)
package aes_pkg;

  localparam int unsigned AES_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } aes_state_e;

  localparam logic [7:0] SBOX_FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] SBOX_INV [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/aes_sbox_engine_if.sv
// Handshake bundle between the round controller and the S-box engine.
//   in_valid/in_ready/in_state/in_inv    : state offered for substitution
//   out_valid/out_ready/out_state/out_inv : finished result and its mode
//   busy                                  : engine is working through groups
// master = round controller side, slave = engine side.
interface aes_sbox_engine_if
  import aes_pkg::*;
#(
  parameter int unsigned NBYTES = 16
);

  logic                           in_valid;
  logic                           in_ready;
  logic [AES_BYTE_W*NBYTES-1:0]   in_state;
  logic                           in_inv;
  logic                           out_valid;
  logic                           out_ready;
  logic [AES_BYTE_W*NBYTES-1:0]   out_state;
  logic                           out_inv;
  logic                           busy;

  modport master (
    output in_valid, in_state, in_inv, out_ready,
    input  in_ready, out_valid, out_state, out_inv, busy
  );

  modport slave (
    input  in_valid, in_state, in_inv, out_ready,
    output in_ready, out_valid, out_state, out_inv, busy
  );

endinterface

// File: rtl/aes_sbox_engine_lane.sv
// One combinational S-box lookup.
//   din  : byte to substitute
//   inv  : 0 = forward S-box, 1 = inverse S-box
//   dout : substituted byte
module aes_sbox_lane
  import aes_pkg::*;
(
  input  logic [AES_BYTE_W-1:0] din,
  input  logic                  inv,
  output logic [AES_BYTE_W-1:0] dout
);

  always_comb begin
    dout = inv ? SBOX_INV[din] : SBOX_FWD[din];
  end

endmodule

// File: rtl/aes_sbox_engine.sv
// Multi-cycle AES SubBytes / InvSubBytes engine.
// Substitutes an NBYTES-byte state LANES bytes per clock, lowest byte group
// first, using the mode captured when the state was accepted.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : handshake bundle (slave side), see aes_sbox_engine_if
module aes_sbox_engine
  import aes_pkg::*;
#(
  parameter int unsigned NBYTES = 16,
  parameter int unsigned LANES  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  aes_sbox_engine_if.slave bus
);

  if (LANES == 0 || (NBYTES % LANES) != 0) begin : g_bad_lanes
    $error("aes_sbox_engine: LANES=%0d must divide NBYTES=%0d", LANES, NBYTES);
  end

  localparam int unsigned STEPS = (LANES == 0) ? 1 : NBYTES / LANES;
  localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  // Grouped view of the working register: group g, lane l is byte g*LANES+l,
  // so the flat bit order matches in_state/out_state exactly.
  typedef logic [STEPS-1:0][LANES-1:0][AES_BYTE_W-1:0] work_t;
  typedef logic [LANES-1:0][AES_BYTE_W-1:0]            group_t;

  aes_state_e        state_q, state_d;
  work_t             work_q, work_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              inv_q;
  logic              accept;
  logic              last_grp;
  group_t            lane_in, lane_out;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    aes_sbox_lane u_lane (
      .din  (lane_in[l]),
      .inv  (inv_q),
      .dout (lane_out[l])
    );
  end

  always_comb begin
    lane_in         = work_q[cnt_q];
    work_d          = work_q;
    work_d[cnt_q]   = lane_out;
    last_grp        = (cnt_q == CNT_W'(STEPS - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        bus.busy = 1'b1;
        if (last_grp) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q <= '0;
      cnt_q  <= '0;
      inv_q  <= 1'b0;
    end else if (accept) begin
      work_q <= bus.in_state;
      cnt_q  <= '0;
      inv_q  <= bus.in_inv;
    end else if (state_q == BUSY) begin
      work_q <= work_d;
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  assign bus.out_state = work_q;
  assign bus.out_inv   = inv_q;

endmodule

// File: tb/tb_aes_sbox_engine.sv
// Self-checking bench for aes_sbox_engine with LANES = 4, 1 and 16.
// Reference S-boxes are derived from GF(2^8) inversion plus the affine map.
module tb_aes_sbox_engine;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // index 0: LANES=4, 1: LANES=1, 2: LANES=16
  logic         drv_valid [3] = '{1'b0, 1'b0, 1'b0};
  logic         drv_inv   [3] = '{1'b0, 1'b0, 1'b0};
  logic         drv_ready [3] = '{1'b0, 1'b0, 1'b0};
  logic [127:0] drv_state [3] = '{128'h0, 128'h0, 128'h0};

  logic         mon_in_ready  [3];
  logic         mon_out_valid [3];
  logic         mon_out_inv   [3];
  logic         mon_busy      [3];
  logic [127:0] mon_out_state [3];

  aes_sbox_engine_if #(.NBYTES(16)) if4  ();
  aes_sbox_engine_if #(.NBYTES(16)) if1  ();
  aes_sbox_engine_if #(.NBYTES(16)) if16 ();

  aes_sbox_engine #(.NBYTES(16), .LANES(4))  u_l4  (.clk(clk), .rst_n(rst_n), .bus(if4));
  aes_sbox_engine #(.NBYTES(16), .LANES(1))  u_l1  (.clk(clk), .rst_n(rst_n), .bus(if1));
  aes_sbox_engine #(.NBYTES(16), .LANES(16)) u_l16 (.clk(clk), .rst_n(rst_n), .bus(if16));

  assign if4.in_valid   = drv_valid[0];
  assign if4.in_state   = drv_state[0];
  assign if4.in_inv     = drv_inv[0];
  assign if4.out_ready  = drv_ready[0];
  assign if1.in_valid   = drv_valid[1];
  assign if1.in_state   = drv_state[1];
  assign if1.in_inv     = drv_inv[1];
  assign if1.out_ready  = drv_ready[1];
  assign if16.in_valid  = drv_valid[2];
  assign if16.in_state  = drv_state[2];
  assign if16.in_inv    = drv_inv[2];
  assign if16.out_ready = drv_ready[2];

  assign mon_in_ready[0]  = if4.in_ready;
  assign mon_out_valid[0] = if4.out_valid;
  assign mon_out_inv[0]   = if4.out_inv;
  assign mon_busy[0]      = if4.busy;
  assign mon_out_state[0] = if4.out_state;
  assign mon_in_ready[1]  = if1.in_ready;
  assign mon_out_valid[1] = if1.out_valid;
  assign mon_out_inv[1]   = if1.out_inv;
  assign mon_busy[1]      = if1.busy;
  assign mon_out_state[1] = if1.out_state;
  assign mon_in_ready[2]  = if16.in_ready;
  assign mon_out_valid[2] = if16.out_valid;
  assign mon_out_inv[2]   = if16.out_inv;
  assign mon_busy[2]      = if16.busy;
  assign mon_out_state[2] = if16.out_state;

  function automatic int steps_of(input int d);
    case (d)
      0:       return 4;
      1:       return 16;
      default: return 1;
    endcase
  endfunction

  // ---------------- reference S-boxes from field arithmetic ----------------
  logic [7:0] fwd_t [256];
  logic [7:0] inv_t [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  task automatic build_tables();
    logic [7:0] av, iv, s;
    for (int a = 0; a < 256; a++) begin
      av = 8'(a);
      iv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(av, 8'(b)) == 8'h01) iv = 8'(b);
      s = iv ^ {iv[6:0], iv[7]} ^ {iv[5:0], iv[7:6]} ^ {iv[4:0], iv[7:5]} ^ {iv[3:0], iv[7:4]} ^ 8'h63;
      fwd_t[av] = s;
      inv_t[s]  = av;
    end
  endtask

  function automatic logic [127:0] subst(input logic [127:0] s, input logic inv);
    logic [15:0][7:0] sv, rv;
    sv = s;
    for (int k = 0; k < 16; k++)
      rv[4'(k)] = inv ? inv_t[sv[4'(k)]] : fwd_t[sv[4'(k)]];
    return rv;
  endfunction

  // ---------------- check helpers ----------------
  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic checkn(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // m_rem: edges of work left; m_done: result waiting for the consumer;
  // m_zero: nothing accepted since reset, so out_state must read zero.
  int           m_rem  [3] = '{0, 0, 0};
  bit           m_done [3] = '{1'b0, 1'b0, 1'b0};
  bit           m_zero [3] = '{1'b1, 1'b1, 1'b1};
  bit           m_inv  [3] = '{1'b0, 1'b0, 1'b0};
  logic [127:0] m_res  [3] = '{128'h0, 128'h0, 128'h0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 3; d++) begin
        m_rem[d]  <= 0;
        m_done[d] <= 1'b0;
        m_zero[d] <= 1'b1;
        m_inv[d]  <= 1'b0;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        if (m_done[d]) begin
          if (drv_ready[d]) m_done[d] <= 1'b0;
        end else if (m_rem[d] != 0) begin
          m_rem[d] <= m_rem[d] - 1;
          if (m_rem[d] == 1) m_done[d] <= 1'b1;
        end else if (drv_valid[d]) begin
          m_res[d]  <= subst(drv_state[d], drv_inv[d]);
          m_inv[d]  <= drv_inv[d];
          m_rem[d]  <= steps_of(d);
          m_zero[d] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      check1($sformatf("in_ready[%0d]", d), mon_in_ready[d], !m_done[d] && m_rem[d] == 0);
      check1($sformatf("out_valid[%0d]", d), mon_out_valid[d], m_done[d]);
      check1($sformatf("busy[%0d]", d), mon_busy[d], m_rem[d] != 0);
      check1($sformatf("out_inv[%0d]", d), mon_out_inv[d], m_inv[d]);
      if (m_done[d]) check($sformatf("out_state[%0d]", d), mon_out_state[d], m_res[d]);
      if (m_zero[d]) check($sformatf("out_state_rst[%0d]", d), mon_out_state[d], 128'h0);
    end
  end

  // ---------------- stimulus tasks (entered and left at a negedge) ----------------
  task automatic send(input int d, input logic [127:0] s, input logic inv);
    int n;
    n = 0;
    while (!mon_in_ready[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check1($sformatf("send_ready[%0d]", d), mon_in_ready[d], 1'b1);
    drv_state[d] = s;
    drv_inv[d]   = inv;
    drv_valid[d] = 1'b1;
    @(negedge clk);
    drv_valid[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, output logic [127:0] r, output int lat, output int bcyc);
    lat  = 0;
    bcyc = 0;
    while (!mon_out_valid[d] && lat < 200) begin
      if (mon_busy[d]) bcyc++;
      @(negedge clk);
      lat++;
    end
    check1($sformatf("done_valid[%0d]", d), mon_out_valid[d], 1'b1);
    r = mon_out_state[d];
  endtask

  task automatic take(input int d);
    drv_ready[d] = 1'b1;
    @(negedge clk);
    drv_ready[d] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] x, y, r, r2, s;
    int lat, bcyc;
    logic m;

    build_tables();
    // Model pins against known FIPS-197 entries.
    check("model_fwd_00", 128'(fwd_t[8'h00]), 128'h63);
    check("model_fwd_53", 128'(fwd_t[8'h53]), 128'hed);
    check("model_inv_00", 128'(inv_t[8'h00]), 128'h52);
    check("model_inv_63", 128'(inv_t[8'h63]), 128'h00);
    check("model_inv_7d", 128'(inv_t[8'h7d]), 128'h13);
    check("model_inv_ff", 128'(inv_t[8'hff]), 128'h7d);

    repeat (3) @(negedge clk);
    check1("rst_in_ready", mon_in_ready[0], 1'b1);
    check1("rst_out_valid", mon_out_valid[0], 1'b0);
    check1("rst_busy", mon_busy[0], 1'b0);
    check1("rst_out_inv", mon_out_inv[0], 1'b0);
    check("rst_out_state", mon_out_state[0], 128'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Forward of all-zero state, LANES=4.
    send(0, 128'h0, 1'b0);
    wait_done(0, r, lat, bcyc);
    check("fwd_zero", r, {16{8'h63}});
    checkn("fwd_zero_lat", lat, 4);
    checkn("fwd_zero_busy", bcyc, 4);
    check1("fwd_zero_inv", mon_out_inv[0], 1'b0);
    take(0);

    // Inverse of all-zero state and selected bytes.
    send(0, 128'h0, 1'b1);
    wait_done(0, r, lat, bcyc);
    check("inv_zero", r, {16{8'h52}});
    check1("inv_zero_inv", mon_out_inv[0], 1'b1);
    take(0);
    s = {{13{8'h00}}, 8'hff, 8'h7d, 8'h63};
    send(0, s, 1'b1);
    wait_done(0, r, lat, bcyc);
    check("inv_bytes", r, {{13{8'h52}}, 8'h7d, 8'h13, 8'h00});
    take(0);

    // Round trips on LANES=1 and LANES=16.
    for (int i = 0; i < 4; i++) begin
      for (int d = 1; d < 3; d++) begin
        x = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(d, x, 1'b0);
        wait_done(d, r, lat, bcyc);
        check($sformatf("rt_fwd[%0d]", d), r, subst(x, 1'b0));
        checkn($sformatf("rt_lat[%0d]", d), lat, steps_of(d));
        take(d);
        send(d, r, 1'b1);
        wait_done(d, r2, lat, bcyc);
        check($sformatf("rt_back[%0d]", d), r2, x);
        take(d);
      end
    end

    // Backpressure: hold the result, ignore offered states.
    x = {$urandom(), $urandom(), $urandom(), $urandom()};
    send(0, x, 1'b0);
    wait_done(0, r, lat, bcyc);
    for (int i = 0; i < 10; i++) begin
      drv_valid[0] = i[0];
      drv_state[0] = {$urandom(), $urandom(), $urandom(), $urandom()};
      drv_inv[0]   = 1'b1;
      check1("bp_valid", mon_out_valid[0], 1'b1);
      check1("bp_in_ready", mon_in_ready[0], 1'b0);
      check("bp_state", mon_out_state[0], r);
      @(negedge clk);
    end
    drv_valid[0] = 1'b0;
    take(0);
    check1("bp_ready_after", mon_in_ready[0], 1'b1);
    y = {$urandom(), $urandom(), $urandom(), $urandom()};
    send(0, y, 1'b1);
    wait_done(0, r, lat, bcyc);
    check("bp_next", r, subst(y, 1'b1));
    checkn("bp_next_lat", lat, 4);
    take(0);

    // Mode and data captured only at accept.
    x = 128'h00112233_44556677_8899aabb_ccddeeff;
    send(0, x, 1'b0);
    drv_inv[0]   = 1'b1;
    drv_state[0] = ~x;
    drv_valid[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    drv_valid[0] = 1'b0;
    wait_done(0, r, lat, bcyc);
    check("iso_state", r, subst(x, 1'b0));
    check("iso_byte0", 128'(r[7:0]), 128'h16);
    check("iso_byte15", 128'(r[127:120]), 128'h63);
    check1("iso_inv", mon_out_inv[0], 1'b0);
    take(0);

    // Reset in the middle of BUSY with cnt=2.
    x = {$urandom(), $urandom(), $urandom(), $urandom()};
    send(0, x, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check1("mid_rst_in_ready", mon_in_ready[0], 1'b1);
    check1("mid_rst_out_valid", mon_out_valid[0], 1'b0);
    check1("mid_rst_busy", mon_busy[0], 1'b0);
    check("mid_rst_state", mon_out_state[0], 128'h0);
    check1("mid_rst_inv", mon_out_inv[0], 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    y = {$urandom(), $urandom(), $urandom(), $urandom()};
    send(0, y, 1'b1);
    wait_done(0, r, lat, bcyc);
    check("post_rst", r, subst(y, 1'b1));
    checkn("post_rst_lat", lat, 4);
    take(0);

    // Random modes with random consumer delay.
    for (int i = 0; i < 6; i++) begin
      x = {$urandom(), $urandom(), $urandom(), $urandom()};
      m = 1'($urandom_range(0, 1));
      send(0, x, m);
      wait_done(0, r, lat, bcyc);
      check("rnd_state", r, subst(x, m));
      checkn("rnd_lat", lat, 4);
      check1("rnd_inv", mon_out_inv[0], m);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      take(0);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
